// File: rtl/mem_access_seq_pkg.sv
// Shared types for the memory-access sequencer: operation encoding, FSM states
// and small decode helpers.
package mem_access_seq_pkg;

  typedef enum logic [2:0] {
    mop_rdw = 3'd0,
    mop_rdb = 3'd1,
    mop_wrw = 3'd2,
    mop_wrb = 3'd3,
    mop_rdi = 3'd4,
    mop_wri = 3'd5
  } mem_op_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PTR  = 3'd1,
    ST_RD   = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4
  } seq_state_t;

  // Unused encodings 6 and 7 behave as a word read.
  function automatic mem_op_t normalize_op(input mem_op_t op);
    case (op)
      mop_rdb, mop_wrw, mop_wrb, mop_rdi, mop_wri: return op;
      default:                                     return mop_rdw;
    endcase
  endfunction

  function automatic logic op_is_byte(input mem_op_t op);
    return (op == mop_rdb) || (op == mop_wrb);
  endfunction

  function automatic logic op_is_write(input mem_op_t op);
    return (op == mop_wrw) || (op == mop_wrb) || (op == mop_wri);
  endfunction

  function automatic logic op_is_indirect(input mem_op_t op);
    return (op == mop_rdi) || (op == mop_wri);
  endfunction

endpackage

// File: rtl/mem_access_seq_timeout_ctr.sv
// Per-access wait counter; expired flags the last permitted strobe cycle.
// With TIMEOUT=0 the counter never advances and expired is constant 0.
module mem_timeout_ctr #(
  parameter int unsigned TIMEOUT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned LIMIT = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != CW'(LIMIT))) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = (TIMEOUT != 0) && enable && (cnt == CW'(LIMIT));

endmodule

// File: rtl/mem_access_seq.sv
// Single request/response engine for word/byte, direct/indirect loads and
// stores against a handshaked memory port. All mem_* and resp_* are registered.
module mem_access_seq
  import mem_access_seq_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned IND_DEPTH = 1,
  parameter int unsigned TIMEOUT   = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  mem_op_t            req_op,
  input  logic [WIDTH-1:0]   req_addr,
  input  logic [WIDTH-1:0]   req_wdata,
  output logic               resp_valid,
  output logic               resp_error,
  output logic [WIDTH-1:0]   resp_rdata,
  output logic [WIDTH-1:0]   mem_address,
  output logic               mem_read,
  output logic               mem_write,
  output logic [WIDTH-1:0]   mem_wdata,
  output logic [WIDTH/8-1:0] mem_byte_enable,
  input  logic [WIDTH-1:0]   mem_rdata,
  input  logic               mem_resp
);

  localparam int unsigned NB = WIDTH / 8;
  localparam int unsigned LB = $clog2(NB);

  seq_state_t        state;
  mem_op_t           op_q;
  logic [LB-1:0]     lane_q;
  logic [WIDTH-1:0]  wdata_q;
  logic [2:0]        ptr_cnt;

  mem_op_t           req_op_n;
  logic [2:0]        ptr_nxt;
  logic [WIDTH-1:0]  rd_shift;
  logic              busy;
  logic              tmr_expired;

  function automatic logic [WIDTH-1:0] word_addr(input logic [WIDTH-1:0] a);
    return a & ~WIDTH'(NB - 1);
  endfunction

  function automatic logic [NB-1:0] lane_en(input logic [WIDTH-1:0] a);
    return NB'(1) << a[LB-1:0];
  endfunction

  assign req_op_n = normalize_op(req_op);
  assign ptr_nxt  = ptr_cnt + 3'd1;
  assign rd_shift = mem_rdata >> {lane_q, 3'b000};
  assign busy     = (state == ST_PTR) || (state == ST_RD) || (state == ST_WR);

  // Timer restarts at every new strobe: on accept (idle) and on each response.
  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (!busy || mem_resp),
    .enable  (busy),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      op_q            <= mop_rdw;
      lane_q          <= '0;
      wdata_q         <= '0;
      ptr_cnt         <= '0;
      req_ready       <= 1'b1;
      resp_valid      <= 1'b0;
      resp_error      <= 1'b0;
      resp_rdata      <= '0;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_address     <= '0;
      mem_wdata       <= '0;
      mem_byte_enable <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_q      <= req_op_n;
            lane_q    <= req_addr[LB-1:0];
            wdata_q   <= req_wdata;
            ptr_cnt   <= '0;
            req_ready <= 1'b0;
            if (op_is_indirect(req_op_n)) begin
              state           <= ST_PTR;
              mem_read        <= 1'b1;
              mem_address     <= word_addr(req_addr);
              mem_byte_enable <= '1;
            end else begin
              state           <= op_is_write(req_op_n) ? ST_WR : ST_RD;
              mem_read        <= !op_is_write(req_op_n);
              mem_write       <= op_is_write(req_op_n);
              if (op_is_byte(req_op_n)) begin
                mem_address     <= req_addr;
                mem_byte_enable <= lane_en(req_addr);
                mem_wdata       <= {NB{req_wdata[7:0]}};
              end else begin
                mem_address     <= word_addr(req_addr);
                mem_byte_enable <= '1;
                mem_wdata       <= req_wdata;
              end
            end
          end
        end
        ST_PTR: begin
          // Each returned pointer becomes the next (word) address.
          if (mem_resp) begin
            ptr_cnt     <= ptr_nxt;
            mem_address <= word_addr(mem_rdata);
            if (ptr_nxt == 3'(IND_DEPTH)) begin
              if (op_is_write(op_q)) begin
                state     <= ST_WR;
                mem_read  <= 1'b0;
                mem_write <= 1'b1;
                mem_wdata <= wdata_q;
              end else begin
                state <= ST_RD;
              end
            end
          end
        end
        ST_RD: begin
          if (mem_resp) begin
            state      <= ST_RESP;
            mem_read   <= 1'b0;
            resp_valid <= 1'b1;
            resp_rdata <= op_is_byte(op_q) ? WIDTH'(rd_shift[7:0]) : mem_rdata;
          end
        end
        ST_WR: begin
          if (mem_resp) begin
            state      <= ST_RESP;
            mem_write  <= 1'b0;
            resp_valid <= 1'b1;
            resp_rdata <= '0;
          end
        end
        ST_RESP: begin
          state           <= ST_IDLE;
          req_ready       <= 1'b1;
          resp_error      <= 1'b0;
          resp_rdata      <= '0;
          mem_address     <= '0;
          mem_wdata       <= '0;
          mem_byte_enable <= '0;
        end
        default: state <= ST_IDLE;
      endcase

      // A response arriving with expiry wins; only a silent last cycle errors out.
      if (busy && !mem_resp && tmr_expired) begin
        state      <= ST_RESP;
        mem_read   <= 1'b0;
        mem_write  <= 1'b0;
        resp_valid <= 1'b1;
        resp_error <= 1'b1;
        resp_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_seq.sv
// Self-checking bench for mem_access_seq: directed scenarios plus randomized
// traffic against a word-addressed memory model kept in the bench.
module tb_mem_access_seq;
  import mem_access_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        req_valid = 1'b0;
  logic        req_ready;
  mem_op_t     req_op = mop_rdw;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        resp_valid, resp_error;
  logic [15:0] resp_rdata;
  logic [15:0] mem_address, mem_wdata;
  logic        mem_read, mem_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_rdata = '0;
  logic        mem_resp = 1'b0;

  logic        b_req_valid = 1'b0;
  logic        b_req_ready;
  mem_op_t     b_req_op = mop_rdw;
  logic [31:0] b_req_addr = '0;
  logic [31:0] b_req_wdata = '0;
  logic        b_resp_valid, b_resp_error;
  logic [31:0] b_resp_rdata;
  logic [31:0] b_mem_address, b_mem_wdata;
  logic        b_mem_read, b_mem_write;
  logic [3:0]  b_mem_byte_enable;
  logic [31:0] b_mem_rdata = '0;
  logic        b_mem_resp = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem_m [int];

  always #5 clk = ~clk;

  mem_access_seq #(.WIDTH(16), .IND_DEPTH(2), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_error(resp_error), .resp_rdata(resp_rdata),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  mem_access_seq #(.WIDTH(32), .IND_DEPTH(1), .TIMEOUT(0)) dut32 (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_op(b_req_op),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .resp_valid(b_resp_valid), .resp_error(b_resp_error), .resp_rdata(b_resp_rdata),
    .mem_address(b_mem_address), .mem_read(b_mem_read), .mem_write(b_mem_write),
    .mem_wdata(b_mem_wdata), .mem_byte_enable(b_mem_byte_enable),
    .mem_rdata(b_mem_rdata), .mem_resp(b_mem_resp)
  );

  function automatic logic [15:0] rd_word(input logic [15:0] a);
    if (mem_m.exists(int'(a))) return mem_m[int'(a)];
    return a ^ 16'h5A5A;
  endfunction

  // Present a request at the current falling edge; returns in strobe cycle 1.
  task automatic accept(input mem_op_t op, input logic [15:0] a, input logic [15:0] w);
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = w;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Serve one memory access after lat wait cycles; reports what the DUT drove.
  task automatic mem_cycle(input int lat, input logic [15:0] rd,
                           output logic o_rd, output logic o_wr,
                           output logic [15:0] o_addr, output logic [15:0] o_wd,
                           output logic [1:0] o_be, output int hi);
    o_rd = mem_read; o_wr = mem_write; o_addr = mem_address;
    o_wd = mem_wdata; o_be = mem_byte_enable; hi = 0;
    for (int i = 0; i < lat; i++) begin
      if (mem_read || mem_write) hi++;
      @(negedge clk);
    end
    mem_resp = 1'b1; mem_rdata = rd;
    if (mem_read || mem_write) hi++;
    @(negedge clk);
    mem_resp = 1'b0; mem_rdata = '0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, resp_error, resp_rdata, mem_read, mem_write,
         mem_address, mem_wdata, mem_byte_enable} !== {1'b1, 54'd0}) begin
      errors++;
      $display("FAIL reset_outputs got ready=%b rv=%b re=%b rd=%h r=%b w=%b a=%h wd=%h be=%b",
               req_ready, resp_valid, resp_error, resp_rdata, mem_read, mem_write,
               mem_address, mem_wdata, mem_byte_enable);
    end
    checks++;
    if ({b_req_ready, b_mem_read, b_mem_write, b_mem_byte_enable} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_wide got ready=%b r=%b w=%b be=%b expected 1 0 0 0000",
               b_req_ready, b_mem_read, b_mem_write, b_mem_byte_enable);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready got %b expected 1", req_ready);
    end
  endtask

  task automatic test_word_read;
    logic o_rd, o_wr; logic [15:0] o_addr, o_wd; logic [1:0] o_be; int hi;
    accept(mop_rdw, 16'h1235, 16'h0);
    mem_cycle(3, 16'hBEEF, o_rd, o_wr, o_addr, o_wd, o_be, hi);
    checks++;
    if ({o_rd, o_wr, o_addr, o_be, 4'(hi)} !== {1'b1, 1'b0, 16'h1234, 2'b11, 4'd4}) begin
      errors++;
      $display("FAIL rdw_strobe got r=%b w=%b a=%h be=%b hi=%0d expected 1 0 1234 11 4",
               o_rd, o_wr, o_addr, o_be, hi);
    end
    checks++;
    if ({resp_valid, resp_error, resp_rdata} !== {2'b10, 16'hBEEF}) begin
      errors++;
      $display("FAIL rdw_resp_cycle5 got v=%b e=%b d=%h expected 1 0 beef",
               resp_valid, resp_error, resp_rdata);
    end
    @(negedge clk);
    checks++;
    if ({resp_valid, req_ready} !== 2'b01) begin
      errors++; $display("FAIL rdw_ready got v=%b ready=%b expected 0 1", resp_valid, req_ready);
    end
  endtask

  task automatic test_byte_write;
    logic o_rd, o_wr; logic [15:0] o_addr, o_wd; logic [1:0] o_be; int hi;
    accept(mop_wrb, 16'h2001, 16'h00A5);
    mem_cycle(0, 16'hFFFF, o_rd, o_wr, o_addr, o_wd, o_be, hi);
    checks++;
    if ({o_rd, o_wr, o_addr, o_wd, o_be} !== {1'b0, 1'b1, 16'h2001, 16'hA5A5, 2'b10}) begin
      errors++;
      $display("FAIL wrb_strobe got r=%b w=%b a=%h wd=%h be=%b expected 0 1 2001 a5a5 10",
               o_rd, o_wr, o_addr, o_wd, o_be);
    end
    checks++;
    if ({resp_valid, resp_error, resp_rdata} !== {2'b10, 16'h0}) begin
      errors++;
      $display("FAIL wrb_resp got v=%b e=%b d=%h expected 1 0 0000", resp_valid, resp_error, resp_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_indirect;
    logic o_rd, o_wr; logic [15:0] o_addr, o_wd; logic [1:0] o_be; int hi;
    logic [15:0] exp_a [3];
    logic [15:0] data [3];
    exp_a[0] = 16'h3000; exp_a[1] = 16'h4000; exp_a[2] = 16'h5000;
    data[0]  = 16'h4000; data[1]  = 16'h5000; data[2]  = 16'h1234;
    accept(mop_rdi, 16'h3000, 16'h0);
    for (int k = 0; k < 3; k++) begin
      mem_cycle(int'($urandom_range(0, 2)), data[k], o_rd, o_wr, o_addr, o_wd, o_be, hi);
      checks++;
      if ({o_rd, o_wr, o_addr, o_be} !== {1'b1, 1'b0, exp_a[k], 2'b11}) begin
        errors++;
        $display("FAIL rdi_access%0d got r=%b w=%b a=%h be=%b expected 1 0 %h 11",
                 k, o_rd, o_wr, o_addr, o_be, exp_a[k]);
      end
    end
    checks++;
    if ({resp_valid, resp_error, resp_rdata} !== {2'b10, 16'h1234}) begin
      errors++;
      $display("FAIL rdi_resp got v=%b e=%b d=%h expected 1 0 1234", resp_valid, resp_error, resp_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout;
    int hi;
    hi = 0;
    accept(mop_rdw, 16'h0100, 16'h0);
    for (int i = 0; i < 12 && !resp_valid; i++) begin
      if (mem_read) hi++;
      @(negedge clk);
    end
    checks++;
    if (hi !== 4) begin
      errors++; $display("FAIL timeout_strobe_len got %0d expected 4", hi);
    end
    checks++;
    if ({resp_valid, resp_error, resp_rdata, mem_read} !== {2'b11, 16'h0, 1'b0}) begin
      errors++;
      $display("FAIL timeout_resp got v=%b e=%b d=%h r=%b expected 1 1 0000 0",
               resp_valid, resp_error, resp_rdata, mem_read);
    end
    @(negedge clk);
    checks++;
    if ({req_ready, resp_error} !== 2'b10) begin
      errors++; $display("FAIL timeout_ready got ready=%b e=%b expected 1 0", req_ready, resp_error);
    end
  endtask

  task automatic test_wide;
    @(negedge clk);
    b_req_valid = 1'b1; b_req_op = mop_rdb; b_req_addr = 32'h3; b_req_wdata = '0;
    @(negedge clk);
    b_req_valid = 1'b0;
    checks++;
    if ({b_mem_read, b_mem_address, b_mem_byte_enable} !== {1'b1, 32'h3, 4'b1000}) begin
      errors++;
      $display("FAIL wide_rdb_strobe got r=%b a=%h be=%b expected 1 00000003 1000",
               b_mem_read, b_mem_address, b_mem_byte_enable);
    end
    b_mem_resp = 1'b1; b_mem_rdata = 32'h80FF0000;
    @(negedge clk);
    b_mem_resp = 1'b0;
    checks++;
    if ({b_resp_valid, b_resp_error, b_resp_rdata} !== {2'b10, 32'h00000080}) begin
      errors++;
      $display("FAIL wide_rdb_resp got v=%b e=%b d=%h expected 1 0 00000080",
               b_resp_valid, b_resp_error, b_resp_rdata);
    end
    @(negedge clk);
    b_req_valid = 1'b1; b_req_op = mop_wrb; b_req_addr = 32'h0000_0106; b_req_wdata = 32'h123456C3;
    @(negedge clk);
    b_req_valid = 1'b0;
    checks++;
    if ({b_mem_write, b_mem_address, b_mem_wdata, b_mem_byte_enable} !==
        {1'b1, 32'h106, 32'hC3C3C3C3, 4'b0100}) begin
      errors++;
      $display("FAIL wide_wrb_strobe got w=%b a=%h wd=%h be=%b expected 1 00000106 c3c3c3c3 0100",
               b_mem_write, b_mem_address, b_mem_wdata, b_mem_byte_enable);
    end
    b_mem_resp = 1'b1;
    @(negedge clk);
    b_mem_resp = 1'b0;
    @(negedge clk);
    b_req_valid = 1'b1; b_req_op = mop_rdw; b_req_addr = 32'h0000_0007;
    @(negedge clk);
    b_req_valid = 1'b0;
    checks++;
    if ({b_mem_read, b_mem_address, b_mem_byte_enable} !== {1'b1, 32'h4, 4'b1111}) begin
      errors++;
      $display("FAIL wide_rdw_strobe got r=%b a=%h be=%b expected 1 00000004 1111",
               b_mem_read, b_mem_address, b_mem_byte_enable);
    end
    b_mem_resp = 1'b1; b_mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    b_mem_resp = 1'b0;
    checks++;
    if ({b_resp_valid, b_resp_rdata} !== {1'b1, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL wide_rdw_resp got v=%b d=%h expected 1 deadbeef", b_resp_valid, b_resp_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore;
    logic o_rd, o_wr; logic [15:0] o_addr, o_wd; logic [1:0] o_be; int hi;
    int writes;
    writes = 0;
    accept(mop_rdw, 16'h0010, 16'h0);
    req_valid = 1'b1; req_op = mop_wrw; req_addr = 16'h0888;
    mem_cycle(1, 16'h1111, o_rd, o_wr, o_addr, o_wd, o_be, hi);
    req_valid = 1'b0;
    checks++;
    if ({resp_valid, resp_rdata, o_addr} !== {1'b1, 16'h1111, 16'h0010}) begin
      errors++;
      $display("FAIL busy_ignore_resp got v=%b d=%h a=%h expected 1 1111 0010",
               resp_valid, resp_rdata, o_addr);
    end
    @(negedge clk);
    mem_resp = 1'b1; mem_rdata = 16'hFFFF;
    @(negedge clk);
    mem_resp = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (resp_valid || mem_read || mem_write) writes++;
      @(negedge clk);
    end
    checks++;
    if (writes !== 0) begin
      errors++; $display("FAIL idle_resp_ignored got %0d active cycles expected 0", writes);
    end
  endtask

  task automatic test_random;
    logic o_rd, o_wr; logic [15:0] o_addr, o_wd; logic [1:0] o_be; int hi;
    int opr, lat;
    logic is_ind, is_wr, is_b;
    logic [15:0] a, w, p, ea, val, wordv, exp_rd, exp_wd, nv;
    logic [1:0] ebe;
    for (int it = 0; it < 40; it++) begin
      checks++;
      if (req_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_ready it=%0d got %b expected 1", it, req_ready);
      end
      opr = int'($urandom_range(0, 7));
      a = 16'($urandom_range(0, 31));
      w = 16'($urandom);
      is_ind = (opr == 4) || (opr == 5);
      is_wr  = (opr == 2) || (opr == 3) || (opr == 5);
      is_b   = (opr == 1) || (opr == 3);
      accept(mem_op_t'(3'(opr)), a, w);
      p = a;
      if (is_ind) begin
        for (int d = 0; d < 2; d++) begin
          ea = p & 16'hFFFE;
          val = rd_word(ea);
          lat = int'($urandom_range(0, 3));
          mem_cycle(lat, val, o_rd, o_wr, o_addr, o_wd, o_be, hi);
          checks++;
          if ({o_rd, o_wr, o_addr, o_be, 4'(hi)} !== {2'b10, ea, 2'b11, 4'(lat + 1)}) begin
            errors++;
            $display("FAIL rand_ptr it=%0d d=%0d got r=%b w=%b a=%h be=%b hi=%0d expected 1 0 %h 11 %0d",
                     it, d, o_rd, o_wr, o_addr, o_be, hi, ea, lat + 1);
          end
          p = val;
        end
      end
      ea = is_b ? p : (p & 16'hFFFE);
      ebe = !is_b ? 2'b11 : (p[0] ? 2'b10 : 2'b01);
      wordv = rd_word(p & 16'hFFFE);
      exp_wd = is_b ? {w[7:0], w[7:0]} : w;
      exp_rd = is_wr ? 16'h0 : (!is_b ? wordv : {8'h00, (p[0] ? wordv[15:8] : wordv[7:0])});
      lat = int'($urandom_range(0, 3));
      mem_cycle(lat, is_wr ? 16'($urandom) : wordv, o_rd, o_wr, o_addr, o_wd, o_be, hi);
      checks++;
      if ({o_rd, o_wr, o_addr, o_be, (is_wr ? o_wd : exp_wd), 4'(hi)} !==
          {!is_wr, is_wr, ea, ebe, exp_wd, 4'(lat + 1)}) begin
        errors++;
        $display("FAIL rand_access it=%0d op=%0d got r=%b w=%b a=%h be=%b wd=%h hi=%0d expected %b %b %h %b %h %0d",
                 it, opr, o_rd, o_wr, o_addr, o_be, o_wd, hi, !is_wr, is_wr, ea, ebe, exp_wd, lat + 1);
      end
      checks++;
      if ({resp_valid, resp_error, resp_rdata} !== {2'b10, exp_rd}) begin
        errors++;
        $display("FAIL rand_resp it=%0d op=%0d got v=%b e=%b d=%h expected 1 0 %h",
                 it, opr, resp_valid, resp_error, resp_rdata, exp_rd);
      end
      if (is_wr) begin
        nv = wordv;
        if (!is_b) nv = w;
        else if (p[0]) nv[15:8] = w[7:0];
        else nv[7:0] = w[7:0];
        mem_m[int'(p & 16'hFFFE)] = nv;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_write;
    int bad;
    bad = 0;
    accept(mop_wrw, 16'h0400, 16'hCAFE);
    @(negedge clk);
    checks++;
    if (mem_write !== 1'b1) begin
      errors++; $display("FAIL midwr_strobe got %b expected 1", mem_write);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({mem_write, mem_read, req_ready} !== 3'b001) begin
      errors++;
      $display("FAIL midwr_async_drop got w=%b r=%b ready=%b expected 0 0 1", mem_write, mem_read, req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp_valid || !req_ready || mem_write) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL midwr_no_resp got %0d bad cycles expected 0", bad);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_word_read();
    test_byte_write();
    test_indirect();
    test_timeout();
    test_wide();
    test_ignore();
    test_random();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
